// File: rtl/trig_scale_engine_pkg.sv
// Shared types and constants for the trig_scale_engine datapath: FSM states,
// mode encodings and the Taylor coefficient generator used by the coefficient ROM.
package trig_scale_engine_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SQUARE  = 3'd1,
        HORNER  = 3'd2,
        SIN_FIX = 3'd3,
        SCALE   = 3'd4
    } state_t;

    localparam logic MODE_COS = 1'b0;
    localparam logic MODE_SIN = 1'b1;

    function automatic longint factorial(input int n);
        longint f;
        f = 1;
        for (int i = 2; i <= n; i++) begin
            f = f * longint'(i);
        end
        return f;
    endfunction

    // (-1)^k / n! with n = 2k (cos) or 2k+1 (sin), rounded to nearest in Q(frac);
    // the magnitude is rounded first so positive and negative terms round symmetrically.
    function automatic longint coefValue(input bit isSin, input int k, input int frac);
        longint f;
        longint mag;
        f   = factorial(isSin ? (2 * k + 1) : (2 * k));
        mag = ((64'sd1 <<< frac) + f / 2) / f;
        return (k % 2 == 1) ? -mag : mag;
    endfunction

endpackage

// File: rtl/trig_scale_engine_coef_rom.sv
// Combinational Taylor coefficient table for cosine and sine, built at elaboration time.
// Unused slots (when TERMS is not a power of two) read as zero.
module trig_coef_rom
    import trig_scale_engine_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 11,
    parameter int TERMS = 4,
    localparam int IW   = $clog2(TERMS)
) (
    input  logic                    mode,
    input  logic [IW-1:0]           index,
    output logic signed [WIDTH-1:0] coef
);

    logic signed [WIDTH-1:0] cosTab [2**IW];
    logic signed [WIDTH-1:0] sinTab [2**IW];

    for (genvar gi = 0; gi < 2**IW; gi++) begin : gTab
        localparam logic signed [WIDTH-1:0] COS_C =
            (gi < TERMS) ? WIDTH'(coefValue(1'b0, gi, FRAC)) : '0;
        localparam logic signed [WIDTH-1:0] SIN_C =
            (gi < TERMS) ? WIDTH'(coefValue(1'b1, gi, FRAC)) : '0;
        assign cosTab[gi] = COS_C;
        assign sinTab[gi] = SIN_C;
    end

    assign coef = (mode == MODE_SIN) ? sinTab[index] : cosTab[index];

endmodule

// File: rtl/trig_scale_engine.sv
// distance = V*cos(X) or V*sin(X) by Horner evaluation of a truncated Taylor series,
// sharing one saturating multiplier across all steps; start/done handshake.
module trig_scale_engine
    import trig_scale_engine_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 11,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] v_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] distance,
    output logic             overflow
);

    localparam int IW = $clog2(TERMS);
    localparam logic [IW-1:0] K_START = IW'(TERMS - 2);
    localparam logic [IW-1:0] K_TOP   = IW'(TERMS - 1);
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t stateReg, stateNext;
    logic signed [WIDTH-1:0] vReg, xReg, x2Reg, accReg, distReg;
    logic [IW-1:0] kReg;
    logic modeReg, doneReg, ovfReg;

    logic signed [WIDTH-1:0]   mulA, mulB, mulRes, coef, addRes;
    logic signed [2*WIDTH-1:0] prod, prodSh;
    logic signed [WIDTH:0]     sum;
    logic mulOvf, addOvf, romMode;
    logic [IW-1:0] romIndex;

    // In IDLE the ROM serves the accept edge (top coefficient, live mode input).
    assign romIndex = (stateReg == IDLE) ? K_TOP : kReg;
    assign romMode  = (stateReg == IDLE) ? mode : modeReg;

    trig_coef_rom #(.WIDTH(WIDTH), .FRAC(FRAC), .TERMS(TERMS)) uRom (
        .mode  (romMode),
        .index (romIndex),
        .coef  (coef)
    );

    always_comb begin
        mulA = '0;
        mulB = '0;
        case (stateReg)
            SQUARE:  begin mulA = xReg;  mulB = xReg;   end
            HORNER:  begin mulA = x2Reg; mulB = accReg; end
            SIN_FIX: begin mulA = xReg;  mulB = accReg; end
            SCALE:   begin mulA = vReg;  mulB = accReg; end
            default: ;
        endcase
    end

    // Arithmetic shift floors toward -inf; saturate if the upper bits are not a sign extension.
    assign prod   = mulA * mulB;
    assign prodSh = prod >>> FRAC;
    assign mulOvf = (prodSh[2*WIDTH-1:WIDTH-1] != '0) && (prodSh[2*WIDTH-1:WIDTH-1] != '1);
    assign mulRes = mulOvf ? (prodSh[2*WIDTH-1] ? MINV : MAXV) : prodSh[WIDTH-1:0];

    assign sum    = {coef[WIDTH-1], coef} + {mulRes[WIDTH-1], mulRes};
    assign addOvf = sum[WIDTH] != sum[WIDTH-1];
    assign addRes = addOvf ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = SQUARE;
            SQUARE:  stateNext = HORNER;
            HORNER:  if (kReg == '0) stateNext = (modeReg == MODE_SIN) ? SIN_FIX : SCALE;
            SIN_FIX: stateNext = SCALE;
            SCALE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vReg    <= '0;
            xReg    <= '0;
            x2Reg   <= '0;
            accReg  <= '0;
            distReg <= '0;
            kReg    <= '0;
            modeReg <= 1'b0;
            doneReg <= 1'b0;
            ovfReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: if (start) begin
                    vReg    <= v_in;
                    xReg    <= x_in;
                    modeReg <= mode;
                    accReg  <= coef;
                    kReg    <= K_START;
                    doneReg <= 1'b0;
                    ovfReg  <= 1'b0;
                end
                SQUARE: begin
                    x2Reg  <= mulRes;
                    ovfReg <= ovfReg | mulOvf;
                end
                HORNER: begin
                    accReg <= addRes;
                    kReg   <= kReg - 1'b1;
                    ovfReg <= ovfReg | mulOvf | addOvf;
                end
                SIN_FIX: begin
                    accReg <= mulRes;
                    ovfReg <= ovfReg | mulOvf;
                end
                SCALE: begin
                    distReg <= mulRes;
                    doneReg <= 1'b1;
                    ovfReg  <= ovfReg | mulOvf;
                end
                default: ;
            endcase
        end
    end

    assign ready    = (stateReg == IDLE);
    assign busy     = ~ready;
    assign done     = doneReg;
    assign distance = distReg;
    assign overflow = ovfReg;

endmodule

// File: tb/tb_trig_scale_engine.sv
// Directed bench for trig_scale_engine at WIDTH=16 FRAC=11 TERMS=4 with hand-computed
// results from the quantised Taylor coefficients (cos: 2048,-1024,85,-3; sin: 2048,-341,17,0).
module tb_trig_scale_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] v_in = '0;
    logic [15:0] x_in = '0;
    logic        ready, busy, done, overflow;
    logic [15:0] distance;

    int errors = 0;
    int checks = 0;
    int prevDist = 0;

    always #5 clk = ~clk;

    trig_scale_engine #(.WIDTH(16), .FRAC(11), .TERMS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .v_in     (v_in),
        .x_in     (x_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .distance (distance),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One operation: accept, optionally hammer start while busy, measure latency, check result.
    task automatic runOp(input string tag, input logic m, input int v, input int x,
                         input int expLat, input int expDist, input logic expOvf, input bit hammer);
        int lat;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        v_in  = 16'(v);
        x_in  = 16'(x);
        @(posedge clk);
        #1;
        check({tag, "_ready_after_accept"}, 32'(ready), 0);
        check({tag, "_done_drop"}, 32'(done), 0);
        check({tag, "_dist_held"}, $signed(distance), prevDist);
        if (!hammer) start = 1'b0;
        v_in = 16'h5A5A;
        x_in = 16'hA5A5;
        mode = ~m;
        lat = 0;
        while (!done && lat < 20) begin
            if (hammer) begin
                check({tag, "_ready_low_busy"}, 32'(ready), 0);
                v_in = 16'($urandom);
                x_in = 16'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, expLat);
        check({tag, "_distance"}, $signed(distance), expDist);
        check({tag, "_overflow"}, 32'(overflow), 32'(expOvf));
        check({tag, "_ready_end"}, 32'(ready), 1);
        prevDist = expDist;
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_distance", $signed(distance), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("cos_x0",       1'b0, 2048,  0,     5, 2048,   1'b0, 1'b0);
        runOp("sin_x0",       1'b1, 2048,  0,     6, 0,      1'b0, 1'b0);
        runOp("cos_x1",       1'b0, 2048,  2048,  5, 1106,   1'b0, 1'b0);
        runOp("sin_x1",       1'b1, 2048,  2048,  6, 1724,   1'b0, 1'b0);
        runOp("cos_x8_sat",   1'b0, 2048,  16384, 5, -4880,  1'b1, 1'b0);
        runOp("cos_ovf_clr",  1'b0, 2048,  0,     5, 2048,   1'b0, 1'b0);
        runOp("cos_scale_sat",1'b0, 32767, 16384, 5, -32768, 1'b1, 1'b0);
        runOp("cos_hammer",   1'b0, -4096, 2048,  5, -2212,  1'b0, 1'b1);

        // Reset in the middle of HORNER must publish nothing and recover immediately.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        v_in  = 16'd2048;
        x_in  = 16'd2048;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_distance", $signed(distance), 0);
        check("mid_rst_ready", 32'(ready), 1);
        check("mid_rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prevDist = 0;
        runOp("sin_after_rst", 1'b1, 2048, 2048, 6, 1724, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("done_level_held", 32'(done), 1);
        check("dist_level_held", $signed(distance), 1724);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
